// File: rtl/add_pkg.sv
// Shared defaults and helpers for the round-robin split-carry adder.
package add_pkg;

   localparam int DEF_WIDTH  = 15;
   localparam int DEF_WIDTH1 = 7;
   localparam int DEF_WIDTH2 = 8;
   localparam int DEF_N      = 4;

   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_arb_rr_if.sv
// Requester/result bundle between the adder block and its environment.
interface add_arb_rr_if
   import add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N,
   parameter int TW    = tag_w(N)
);

   logic                 ena;
   logic [N-1:0]         req;
   logic [N*WIDTH-1:0]   x_in;
   logic [N*WIDTH-1:0]   y_in;
   logic [N-1:0]         gnt;
   logic [WIDTH-1:0]     sum_out;
   logic                 vld_out;
   logic [TW-1:0]        tag_out;
   logic [15:0]          ops_cnt;

   modport master (
      output ena, req, x_in, y_in,
      input  gnt, sum_out, vld_out, tag_out, ops_cnt
   );

   modport slave (
      input  ena, req, x_in, y_in,
      output gnt, sum_out, vld_out, tag_out, ops_cnt
   );

endinterface

// File: rtl/add_pipe2.sv
// Two-stage split-carry adder: segment sums first, carry fold-in second.
module add_pipe2
   import add_pkg::*;
#(
   parameter int W1 = DEF_WIDTH1,
   parameter int W2 = DEF_WIDTH2,
   parameter int TW = tag_w(DEF_N)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ena_i,
   input  logic             vld_i,
   input  logic [TW-1:0]    tag_i,
   input  logic [W1+W2-1:0] a_i,
   input  logic [W1+W2-1:0] b_i,
   output logic             vld_o,
   output logic [TW-1:0]    tag_o,
   output logic [W1+W2-1:0] sum_o
);

   localparam int W = W1 + W2;

   logic [W1:0]   lo_d;
   logic [W1-1:0] lo_q;
   logic          cy_q;
   logic [W2-1:0] hi_q;
   logic [W-1:0]  sum_q;
   logic [1:0]    vld_q;
   logic [TW-1:0] tag1_q;
   logic [TW-1:0] tag2_q;

   assign lo_d = {1'b0, a_i[W1-1:0]} + {1'b0, b_i[W1-1:0]};

   // Final carry-out of the MSB segment is dropped: modulo 2^W.
   always_ff @(posedge clk) begin
      if (ena_i) begin
         {cy_q, lo_q} <= lo_d;
         hi_q         <= a_i[W-1:W1] + b_i[W-1:W1];
         sum_q        <= {hi_q + W2'(cy_q), lo_q};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_q  <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
      end else if (ena_i) begin
         vld_q  <= {vld_q[0], vld_i};
         tag1_q <= tag_i;
         tag2_q <= tag1_q;
      end
   end

   assign vld_o = vld_q[1];
   assign tag_o = tag2_q;
   assign sum_o = sum_q;

endmodule

// File: rtl/add_arb_rr.sv
// Round-robin arbiter feeding a shared split-carry adder pipeline.
module add_arb_rr
   import add_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WIDTH1 = DEF_WIDTH1,
   parameter int WIDTH2 = DEF_WIDTH2,
   parameter int N      = DEF_N
) (
   input  logic       clk,
   input  logic       reset_n,
   add_arb_rr_if.slave bus
);

   localparam int TW = tag_w(N);

   logic [TW-1:0]    rr_q;
   logic [TW-1:0]    rr_d;
   logic [TW-1:0]    gidx;
   logic [TW-1:0]    cand;
   logic             hit;
   logic             cv_q;
   logic [TW-1:0]    ct_q;
   logic [WIDTH-1:0] cx_q;
   logic [WIDTH-1:0] cy_q;
   logic             pv;
   logic [TW-1:0]    pt;
   logic [WIDTH-1:0] ps;
   logic             vo_q;
   logic [TW-1:0]    to_q;
   logic [WIDTH-1:0] so_q;
   logic [15:0]      ops_q;
   logic [15:0]      ops_d;

   // First asserted request at or after rr, searching upward mod N.
   always_comb begin
      hit  = 1'b0;
      gidx = '0;
      cand = '0;
      if (bus.ena && reset_n) begin
         for (int k = 0; k < N; k++) begin
            cand = TW'((int'(rr_q) + k) % N);
            if (!hit && bus.req[cand]) begin
               hit  = 1'b1;
               gidx = cand;
            end
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (hit) begin
         rr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
      end
   end

   assign bus.gnt = hit ? (N'(1) << gidx) : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_q <= '0;
         cv_q <= 1'b0;
         ct_q <= '0;
      end else if (bus.ena) begin
         rr_q <= rr_d;
         cv_q <= hit;
         ct_q <= gidx;
      end
   end

   always_ff @(posedge clk) begin
      if (hit) begin
         cx_q <= bus.x_in[gidx*WIDTH +: WIDTH];
         cy_q <= bus.y_in[gidx*WIDTH +: WIDTH];
      end
   end

   add_pipe2 #(
      .W1 (WIDTH1),
      .W2 (WIDTH2),
      .TW (TW)
   ) u_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .ena_i   (bus.ena),
      .vld_i   (cv_q),
      .tag_i   (ct_q),
      .a_i     (cx_q),
      .b_i     (cy_q),
      .vld_o   (pv),
      .tag_o   (pt),
      .sum_o   (ps)
   );

   assign ops_d = ops_q + 16'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vo_q  <= 1'b0;
         to_q  <= '0;
         so_q  <= '0;
         ops_q <= '0;
      end else if (bus.ena) begin
         vo_q <= pv;
         if (pv) begin
            to_q  <= pt;
            so_q  <= ps;
            ops_q <= ops_d;
         end
      end
   end

   assign bus.vld_out = vo_q;
   assign bus.tag_out = to_q;
   assign bus.sum_out = so_q;
   assign bus.ops_cnt = ops_q;

endmodule

// File: tb/tb_add_arb_rr.sv
// Vector table plus scoreboard bench for add_arb_rr.
module tb_add_arb_rr;
   import add_pkg::*;

   localparam int W  = 15;
   localparam int N  = 4;
   localparam int TW = 2;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   add_arb_rr_if #(.WIDTH(W), .N(N)) bus ();

   add_arb_rr #(
      .WIDTH  (W),
      .WIDTH1 (7),
      .WIDTH2 (8),
      .N      (N)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [W-1:0]  sum;
      logic [TW-1:0] tag;
      int            due;
   } exp_t;

   typedef struct {
      logic [3:0]   req;
      logic [3:0]   gnt;
      logic [W-1:0] x;
      logic [W-1:0] y;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   en_cnt  = 0;
   int   ops_exp = 0;
   logic last_vld = 1'b0;
   logic [W-1:0] xv[N];
   logic [W-1:0] yv[N];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic set_ops(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int i = 0; i < N; i++) begin
         xv[i] = x + W'(i);
         yv[i] = y;
      end
      bus.x_in = {xv[3], xv[2], xv[1], xv[0]};
      bus.y_in = {yv[3], yv[2], yv[1], yv[0]};
   endtask

   // One clock: check gnt, predict, then check what the edge produced.
   task automatic tick(input logic [3:0] eg);
      logic en;
      logic rn;
      exp_t e;
      int   gi;
      @(negedge clk);
      en = bus.ena;
      rn = reset_n;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      if (en && rn && eg != 4'b0) begin
         gi = 0;
         for (int i = 0; i < N; i++) if (eg[i]) gi = i;
         e.sum = xv[gi] + yv[gi];
         e.tag = TW'(gi);
         e.due = en_cnt + 4;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!rn) begin
         sb.delete();
         ops_exp  = 0;
         last_vld = 1'b0;
         chk("rst_vld", 32'(bus.vld_out), 32'd0);
         chk("rst_ops", 32'(bus.ops_cnt), 32'd0);
         chk("rst_sum", 32'(bus.sum_out), 32'd0);
         chk("rst_tag", 32'(bus.tag_out), 32'd0);
      end else if (!en) begin
         chk("hold_vld", 32'(bus.vld_out), 32'(last_vld));
         chk("hold_ops", 32'(bus.ops_cnt), 32'(ops_exp));
      end else begin
         en_cnt++;
         if (bus.vld_out) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_vld: got tag %0d want no result",
                        bus.tag_out);
            end else begin
               e = sb.pop_front();
               chk("sum", 32'(bus.sum_out), 32'(e.sum));
               chk("tag", 32'(bus.tag_out), 32'(e.tag));
               chk("latency", 32'(en_cnt), 32'(e.due));
               ops_exp++;
            end
         end else if (sb.size() > 0 && sb[0].due <= en_cnt) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_vld: got none want tag %0d", sb[0].tag);
            void'(sb.pop_front());
         end
         last_vld = bus.vld_out;
         chk("ops_cnt", 32'(bus.ops_cnt), 32'(ops_exp));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.ena = 1'b0;
      bus.req = '0;
      set_ops('0, '0);
      tick(4'b0000);
      tick(4'b0000);
      reset_n = 1'b1;
      bus.ena = 1'b1;

      vt.push_back('{4'b0001, 4'b0001, 15'h0001, 15'h0002});
      vt.push_back('{4'b0000, 4'b0000, 15'h0000, 15'h0000});
      vt.push_back('{4'b0000, 4'b0000, 15'h0000, 15'h0000});
      vt.push_back('{4'b0000, 4'b0000, 15'h0000, 15'h0000});
      vt.push_back('{4'b0001, 4'b0001, 15'h007F, 15'h0001});
      vt.push_back('{4'b0001, 4'b0001, 15'h7FFF, 15'h0001});
      vt.push_back('{4'b0001, 4'b0001, 15'h3F80, 15'h0080});
      vt.push_back('{4'b1000, 4'b1000, 15'h0011, 15'h0022});
      for (int i = 0; i < 8; i++)
         vt.push_back('{4'b1111, 4'(1 << (i % 4)), 15'h1234, 15'h0F0F});
      vt.push_back('{4'b0100, 4'b0100, 15'h0100, 15'h0023});
      vt.push_back('{4'b0011, 4'b0001, 15'h0100, 15'h0023});
      vt.push_back('{4'b0011, 4'b0010, 15'h0100, 15'h0023});
      for (int i = 0; i < 4; i++)
         vt.push_back('{4'b0000, 4'b0000, 15'h0000, 15'h0000});

      foreach (vt[i]) begin
         bus.req = vt[i].req;
         set_ops(vt[i].x, vt[i].y);
         tick(vt[i].gnt);
      end

      // Freeze with three operations in flight.
      set_ops(15'h5555, 15'h2AAB);
      bus.req = 4'b1111;
      tick(4'b0100);
      tick(4'b1000);
      tick(4'b0001);
      bus.ena = 1'b0;
      tick(4'b0000);
      tick(4'b0000);
      bus.ena = 1'b1;
      bus.req = 4'b0000;
      repeat (5) tick(4'b0000);
      chk("freeze_drain", 32'(sb.size()), 32'd0);

      // Reset with two operations in flight.
      set_ops(15'h0700, 15'h0101);
      bus.req = 4'b1111;
      tick(4'b0010);
      tick(4'b0100);
      reset_n = 1'b0;
      tick(4'b0000);
      reset_n = 1'b1;
      tick(4'b0001);
      bus.req = 4'b0000;
      repeat (6) tick(4'b0000);
      chk("reset_drain", 32'(sb.size()), 32'd0);
      chk("reset_ops", 32'(bus.ops_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/add_arb_rr.md
ADD_ARB_RR -- requirements
Module: add_arb_rr

Interface
REQ-001 Parameter WIDTH, 15, total operand/result bit width.
REQ-002 Parameter WIDTH1, 7, LSB segment width of the split-carry adder.
REQ-003 Parameter WIDTH2, 8, MSB segment width; WIDTH SHALL equal WIDTH1+WIDTH2.
REQ-004 Parameter N, 4, number of requesters; TW = clog2(N) tag width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 ena  in  1  global enable; low freezes all state.
REQ-008 req  in  N  per-requester add request, held until granted.
REQ-009 x_in  in  N*WIDTH  packed operand x, requester i at [i*WIDTH +: WIDTH].
REQ-010 y_in  in  N*WIDTH  packed operand y, same packing.
REQ-011 gnt  out  N  one-hot grant, combinational from req, pointer, ena.
REQ-012 sum_out  out  WIDTH  registered result.
REQ-013 vld_out  out  1  sum_out/tag_out valid, one cycle per operation.
REQ-014 tag_out  out  TW  index of requester owning sum_out.
REQ-015 ops_cnt  out  16  registered count of completed operations.

Function
REQ-016 Arbitration SHALL be round-robin: gnt selects the first asserted req at or after pointer rr, searching upward modulo N.
REQ-017 gnt SHALL be all-zero when ena=0, reset_n=0, or req=0.
REQ-018 On an edge with ena=1 and gnt[i]=1, operands of requester i and tag i SHALL be captured; rr SHALL become (i+1) mod N.
REQ-019 Edge with no grant: rr unchanged, a bubble (valid=0) enters the pipeline.
REQ-020 Adder SHALL be split-carry: LSB segment added first with carry registered, carry added into registered MSB sum in the following stage.
REQ-021 Latency: result of operands captured at edge E SHALL appear on sum_out with vld_out=1 after edge E+3 (capture, LSB/MSB stage, carry stage+output register).
REQ-022 Throughput: one operation per enabled cycle; back-to-back grants SHALL produce back-to-back vld_out.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; final carry-out discarded, no overflow flag.
REQ-024 Valid and tag SHALL travel in a shift pipeline aligned with the adder stages.
REQ-025 ena=0: adder registers, valid/tag pipeline, rr, ops_cnt and all outputs hold; no operation lost or duplicated when ena returns to 1.
REQ-026 ops_cnt SHALL increment on each enabled edge where a valid result is loaded into the output register; wraps 0xFFFF->0.
REQ-027 Requester dropping req before grant SHALL be skipped without side effects.

Reset
REQ-028 reset_n=0 at an edge: rr=0, all pipeline valid bits=0, vld_out=0, sum_out=0, tag_out=0, ops_cnt=0; reset SHALL override ena.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no stale vld_out after reset release.
REQ-030 Operand data registers need no reset; only control/valid state and outputs.

Structure
REQ-031 Shared package add_pkg SHALL hold default WIDTH/WIDTH1/WIDTH2/N constants and the tag-width function.
REQ-032 Sub-module add_pipe2 SHALL implement the split-carry two-stage adder with enable and valid/tag sideband; the arbiter, rr pointer and ops_cnt live in add_arb_rr.

Verification
REQ-033 Single request: req=0001, x0=1, y0=2 -> gnt=0001 same cycle; 3 edges later sum_out=3, tag_out=0, vld_out=1 for one cycle; ops_cnt=1.
REQ-034 All requesters constantly requesting, 8 cycles -> grant order 0,1,2,3,0,1,2,3; vld_out high 8 consecutive cycles with matching tags.
REQ-035 Carry across split: x=0x007F, y=0x0001 -> 0x0080; x=0x7FFF, y=0x0001 -> 0x0000; x=0x3F80, y=0x0080 -> 0x4000.
REQ-036 ena low 2 cycles with 3 ops in flight -> outputs and gnt frozen (gnt=0); after ena=1 exactly 3 results, correct order, none duplicated.
REQ-037 reset_n low one cycle with 2 ops in flight -> next cycle vld_out=0, ops_cnt=0, rr=0; no result for flushed ops ever appears.
REQ-038 Sparse requests: req=0100 then req=0011 -> grants 2, then 0, then 1 (pointer wrap past N-1).
